// File: rtl/muldiv_unit_rv32m.sv
// muldiv_unit_rv32m: iterative RV32M multiply/divide unit.
// One shared 32-step engine: a radix-2 shift-add multiplier and a restoring divider
// that both work on operand magnitudes. The sign fix-up and the special cases
// are applied in one FIXUP cycle, so every opcode has the same latency.
module muldiv_unit_rv32m #(
   parameter int data_width = 32,
   parameter int iter_count = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [5:0]            ALU_Control,
   input  logic [data_width-1:0] operand_A,
   input  logic [data_width-1:0] operand_B,
   input  logic                  flush,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic [data_width-1:0] result,
   output logic                  div_by_zero
);

   localparam int W = data_width;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_FIXUP = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // funct3 encodings
   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;
   localparam logic [2:0] F_REMU   = 3'b111;

   state_t         state_q;
   logic [2:0]     op_q;
   logic [W-1:0]   opnd_q;      // multiplicand (multiply) or divisor (divide) magnitude
   logic [W-1:0]   hi_q;        // product high half / partial remainder
   logic [W-1:0]   lo_q;        // multiplier / product low half / dividend-quotient
   logic [W-1:0]   a_raw_q;     // original dividend, returned by REM/REMU on divide by zero
   logic           b_zero_q;
   logic           neg_res_q;   // product or quotient must be negated
   logic           neg_rem_q;   // remainder must be negated
   logic [5:0]     cnt_q;
   logic [W-1:0]   res_fix_q;
   logic           dbz_fix_q;
   logic           ready_q;
   logic           busy_q;
   logic           done_q;
   logic [W-1:0]   result_q;
   logic           dbz_q;

   logic           accept_s;
   logic           a_signed_s;
   logic           b_signed_s;
   logic           sign_a_s;
   logic           sign_b_s;
   logic [W-1:0]   a_mag_s;
   logic [W-1:0]   b_mag_s;
   logic [W:0]     mul_acc_s;
   logic [W:0]     div_shift_s;
   logic [W-1:0]   div_diff_s;
   logic           q_bit_s;
   logic [W-1:0]   hi_d;
   logic [W-1:0]   lo_d;
   logic [2*W-1:0] prod_s;
   logic [2*W-1:0] prod_fix_s;
   logic [W-1:0]   quo_fix_s;
   logic [W-1:0]   rem_fix_s;
   logic [W-1:0]   res_fix_d;
   logic           dbz_fix_d;

   // Accept decode: which operands are signed for the requested opcode, and their magnitudes
   always_comb begin
      accept_s   = start & ready_q & (ALU_Control[5:3] == 3'b100);
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      case (ALU_Control[2:0])
         F_MULH:   begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         F_MULHSU: begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
         F_DIV:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         F_REM:    begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
         default:  begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
      endcase
      sign_a_s = operand_A[W-1] & a_signed_s;
      sign_b_s = operand_B[W-1] & b_signed_s;
      if (sign_a_s) begin
         a_mag_s = -operand_A;
      end else begin
         a_mag_s = operand_A;
      end
      if (sign_b_s) begin
         b_mag_s = -operand_B;
      end else begin
         b_mag_s = operand_B;
      end
   end

   // One engine step: shift-add for multiply, restoring subtract for divide
   always_comb begin
      mul_acc_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
      div_shift_s = {hi_q, lo_q[W-1]};
      div_diff_s  = div_shift_s[W-1:0] - opnd_q;
      q_bit_s     = (div_shift_s >= {1'b0, opnd_q});
      if (op_q[2]) begin
         if (q_bit_s) begin
            hi_d = div_diff_s;
         end else begin
            hi_d = div_shift_s[W-1:0];
         end
         lo_d = {lo_q[W-2:0], q_bit_s};
      end else begin
         hi_d = mul_acc_s[W:1];
         lo_d = {mul_acc_s[0], lo_q[W-1:1]};
      end
   end

   // Sign correction, half selection and divide-by-zero substitution
   always_comb begin
      prod_s = {hi_q, lo_q};
      if (neg_res_q) begin
         prod_fix_s = -prod_s;
         quo_fix_s  = -lo_q;
      end else begin
         prod_fix_s = prod_s;
         quo_fix_s  = lo_q;
      end
      if (neg_rem_q) begin
         rem_fix_s = -hi_q;
      end else begin
         rem_fix_s = hi_q;
      end
      case (op_q)
         F_MUL:             res_fix_d = prod_fix_s[W-1:0];
         F_MULH, F_MULHSU,
         F_MULHU:           res_fix_d = prod_fix_s[2*W-1:W];
         F_DIV, F_DIVU:     res_fix_d = b_zero_q ? {W{1'b1}} : quo_fix_s;
         F_REM, F_REMU:     res_fix_d = b_zero_q ? a_raw_q : rem_fix_s;
         default:           res_fix_d = {W{1'b0}};
      endcase
      dbz_fix_d = op_q[2] & b_zero_q;
   end

   // Control FSM with all state, datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= 3'b000;
         opnd_q    <= {W{1'b0}};
         hi_q      <= {W{1'b0}};
         lo_q      <= {W{1'b0}};
         a_raw_q   <= {W{1'b0}};
         b_zero_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= 6'd0;
         res_fix_q <= {W{1'b0}};
         dbz_fix_q <= 1'b0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= {W{1'b0}};
         dbz_q     <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (accept_s) begin
                  state_q   <= S_CALC;
                  ready_q   <= 1'b0;
                  dbz_q     <= 1'b0;
                  op_q      <= ALU_Control[2:0];
                  opnd_q    <= ALU_Control[2] ? b_mag_s : a_mag_s;
                  lo_q      <= ALU_Control[2] ? a_mag_s : b_mag_s;
                  hi_q      <= {W{1'b0}};
                  a_raw_q   <= operand_A;
                  b_zero_q  <= (operand_B == {W{1'b0}});
                  neg_res_q <= sign_a_s ^ sign_b_s;
                  neg_rem_q <= sign_a_s;
                  cnt_q     <= 6'd0;
               end
            end
            S_CALC: begin
               busy_q <= 1'b1;
               hi_q   <= hi_d;
               lo_q   <= lo_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == 6'(iter_count - 1)) begin
                  state_q <= S_FIXUP;
               end
            end
            S_FIXUP: begin
               res_fix_q <= res_fix_d;
               dbz_fix_q <= dbz_fix_d;
               state_q   <= S_DONE;
            end
            S_DONE: begin
               result_q <= res_fix_q;
               dbz_q    <= dbz_fix_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               ready_q  <= 1'b1;
               state_q  <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_unit_rv32m.md
Name: muldiv_unit_rv32m

Overview:
- Iterative multi-cycle execution unit for the RV32M instructions: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage and takes the same 6-bit ALU_Control bus and operand pair.
- Returns its result through a start/busy/done handshake; the pipeline stalls while busy is high.
- Uses a radix-2 shift-add multiplier and a restoring divider with one shared 32-step iteration engine.

Parameters:
- data_width, 32, operand and result width; only 32 is supported.
- iter_count, 32, iteration steps per operation; must equal data_width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when ready=1 and ALU_Control is an M code.
- ALU_Control  input  6  operation code; M codes are bit5=1 with funct3 in bits[2:0]:
  - 100000 MUL
  - 100001 MULH
  - 100010 MULHSU
  - 100011 MULHU
  - 100100 DIV
  - 100101 DIVU
  - 100110 REM
  - 100111 REMU
- operand_A  input  data_width  rs1 (multiplicand or dividend), sampled at accept.
- operand_B  input  data_width  rs2 (multiplier or divisor), sampled at accept.
- flush  input  1  synchronous abort of any in-flight operation.
- ready  output  1  high in IDLE only.
- busy  output  1  high from the cycle after accept until done is asserted.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  data_width  final result; holds its value until the next accept.
- div_by_zero  output  1  valid with done; high when a DIV/DIVU/REM/REMU had operand_B=0.

Behaviour:
- Reset (asynchronous, rst=1) values:
  - FSM=IDLE, ready=1, busy=0, done=0, result=0, div_by_zero=0.
  - All internal registers are cleared.
  - Reset mid-operation discards the operation; no done is produced.
- FSM states: IDLE, CALC, FIXUP, DONE.
  - IDLE -> CALC on accept (start & ready & ALU_Control[5:3]==3'b100).
    - Latch the opcode.
    - Latch the operand magnitudes: take the absolute value where the operand is signed for that opcode. Signed A: MULH, MULHSU, DIV, REM. Signed B: MULH, DIV, REM.
    - Latch the result sign flags.
    - Clear the 6-bit step counter.
  - start with a non-M code, or with start=0: stay in IDLE, no state change.
  - CALC: one iteration per cycle; counter increments; after iter_count cycles go to FIXUP.
    - Multiply: 64-bit product register {hi, lo}. If lo[0], hi += multiplicand; then shift the product right by 1, capturing the carry.
    - Divide: remainder register R (33-bit). R = {R, Q[31]} - divisor when non-negative, restoring otherwise; quotient bit shifts into Q.
  - FIXUP (1 cycle): apply sign correction and select the result half, then go to DONE.
    - MUL: low 32 bits.
    - MULH, MULHSU, MULHU: high 32 bits of the two's-complement-corrected 64-bit product.
    - Quotient sign = signA XOR signB.
    - Remainder sign = sign of the dividend.
  - DONE: done=1 and result register updated for this cycle only; next state IDLE, ready=1.
- Latency: accept on edge N gives done=1 in the cycle after edge N+34. All opcodes have fixed, identical latency.
- Special cases (resolved in FIXUP, same latency):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return operand_A; div_by_zero=1.
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0; no flag.
- start while busy is ignored; ready=0 blocks it.
- flush=1 in any state: FSM goes to IDLE on the next edge, busy=0, done not asserted, result unchanged.
- flush and start asserted together in IDLE: flush wins; no accept.
- Operands may change after accept without affecting the result.

Test Plan:
- MUL A=7, B=0xFFFFFFFD (-3) -> done exactly 34 cycles after accept, result=0xFFFFFFEB, busy high for 33 cycles in between.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with div_by_zero=1; REMU 5/0 -> 5 with div_by_zero=1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Accept MUL, then pulse flush at cycle 10 -> ready=1 next cycle, no done, result keeps its previous value. Assert rst asynchronously at cycle 20 of a DIV -> all outputs take reset values immediately.
- start held high with ALU_Control=000000 (ADD) -> no accept, busy stays 0. start re-pulsed during CALC -> ignored, single done.
